// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/imm/mem/exec sequencer for the eight-bit CPU.
// Owns PC, IR, immediate latch, a 4x8 register file and the zero flag; drives the
// external combinational ALU and one unified req/ack memory port.
// Optional build macro CPU_CTRL_HALT_EN: opcode 15 enters a HALT state that only
// reset leaves. Without it, opcode 15 is a NOP and halted is tied low.
module cpu_ctrl #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned NREGS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] alu_ina,
    output logic [7:0] alu_inb,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_zf,
    output logic [7:0] pc,
    output logic       retire,
    output logic       halted
);

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;
    localparam int unsigned RW  = 2;

    // Sequencer states
    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_IMM   = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
`ifdef CPU_CTRL_HALT_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    // Opcode encoding (instruction bits [7:4])
    localparam logic [OPW-1:0] OP_AND   = 4'd0;
    localparam logic [OPW-1:0] OP_OR    = 4'd1;
    localparam logic [OPW-1:0] OP_ADD   = 4'd2;
    localparam logic [OPW-1:0] OP_SUB   = 4'd3;
    localparam logic [OPW-1:0] OP_INC   = 4'd4;
    localparam logic [OPW-1:0] OP_DEC   = 4'd5;
    localparam logic [OPW-1:0] OP_COMP  = 4'd6;
    localparam logic [OPW-1:0] OP_CHECK = 4'd7;
    localparam logic [OPW-1:0] OP_LOAD  = 4'd8;
    localparam logic [OPW-1:0] OP_STORE = 4'd9;
    localparam logic [OPW-1:0] OP_LI    = 4'd10;
    localparam logic [OPW-1:0] OP_JMP   = 4'd11;
    localparam logic [OPW-1:0] OP_JNZ   = 4'd12;
`ifdef CPU_CTRL_HALT_EN
    localparam logic [OPW-1:0] OP_HALT  = 4'd15;
`endif

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          zf_q, zf_d;
    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    logic [OPW-1:0] op;
    logic [RW-1:0]  rd;
    logic [RW-1:0]  rs;
    logic [OPW-1:0] fetch_op;

    // Instruction field decode of the latched IR and of the byte being fetched
    always_comb begin
        op       = ir_q[7:4];
        rd       = ir_q[3:2];
        rs       = ir_q[1:0];
        fetch_op = mem_rdata[7:4];
    end

    // Next-state, datapath updates and combinational memory/ALU/retire outputs
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
        zf_d      = zf_q;
        regs_d    = regs_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        alu_ina   = '0;
        alu_inb   = '0;
        alu_op    = OP_LOAD;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d = mem_rdata;
                    pc_d = pc_q + DW'(1);
                    case (fetch_op)
                        OP_LI, OP_JMP, OP_JNZ: state_d = S_IMM;
                        OP_LOAD, OP_STORE:     state_d = S_MEM;
`ifdef CPU_CTRL_HALT_EN
                        OP_HALT:               state_d = S_HALT;
`endif
                        default:               state_d = S_EXEC;
                    endcase
                end
            end

            S_IMM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    imm_d   = mem_rdata;
                    pc_d    = pc_q + DW'(1);
                    state_d = S_EXEC;
                end
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = regs_q[rs];
                if (op == OP_STORE) begin
                    mem_we    = 1'b1;
                    mem_wdata = regs_q[rd];
                end
                if (mem_ack) begin
                    if (op == OP_LOAD) begin
                        regs_d[rd] = mem_rdata;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXEC: begin
                retire  = 1'b1;
                state_d = S_FETCH;
                case (op)
                    OP_AND, OP_OR, OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                        alu_ina    = regs_q[rd];
                        alu_inb    = regs_q[rs];
                        alu_op     = op;
                        regs_d[rd] = alu_out;
                    end
                    OP_COMP, OP_CHECK: begin
                        alu_ina = regs_q[rd];
                        alu_inb = regs_q[rs];
                        alu_op  = op;
                        zf_d    = alu_zf;
                    end
                    OP_LI: begin
                        alu_ina    = imm_q;
                        alu_op     = OP_LI;
                        regs_d[rd] = alu_out;
                    end
                    OP_JMP: begin
                        pc_d = imm_q;
                    end
                    OP_JNZ: begin
                        // pc already points past the immediate when not taken
                        if (!zf_q) begin
                            pc_d = imm_q;
                        end
                    end
                    default: begin
                        // reserved opcodes retire as NOPs
                    end
                endcase
            end

`ifdef CPU_CTRL_HALT_EN
            S_HALT: begin
                // parked until reset; no memory traffic, no retire
            end
`endif

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences the bus and retire immediately, before the clock edge
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            imm_q   <= '0;
            zf_q    <= 1'b0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            zf_q    <= zf_d;
            regs_q  <= regs_d;
        end
    end

    assign pc = pc_q;

    // Halt indication follows the registered state
`ifdef CPU_CTRL_HALT_EN
    assign halted = rst_n && (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed self-checking bench for cpu_ctrl with a behavioural ALU
// and a 256-byte memory responder with programmable ack wait states.
// Honours CPU_CTRL_HALT_EN for the opcode-15 scenario.
module tb_cpu_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] alu_ina;
    logic [7:0] alu_inb;
    logic [3:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_zf;
    logic [7:0] pc;
    logic       retire;
    logic       halted;

    logic [7:0] mem [256];
    int         wait_cycles;
    int         wait_cnt;
    logic       force_ack;
    int         cyc;
    int         checks;
    int         failures;

    cpu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .alu_ina   (alu_ina),
        .alu_inb   (alu_inb),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_zf    (alu_zf),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: COMP subtracts, CHECK passes A, LI/LOAD pass A
    always_comb begin
        case (alu_op)
            4'd0:    alu_out = alu_ina & alu_inb;
            4'd1:    alu_out = alu_ina | alu_inb;
            4'd2:    alu_out = alu_ina + alu_inb;
            4'd3:    alu_out = alu_ina - alu_inb;
            4'd4:    alu_out = alu_ina + 8'd1;
            4'd5:    alu_out = alu_ina - 8'd1;
            4'd6:    alu_out = alu_ina - alu_inb;
            default: alu_out = alu_ina;
        endcase
        alu_zf = (alu_out == 8'd0);
    end

    // Memory responder: ack after wait_cycles idle cycles, or forced
    assign mem_ack   = force_ack | (mem_req && (wait_cnt == wait_cycles));
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hD0;
    endtask

    // Reset for two edges, release at a falling edge; sample point there is cycle 1
    task automatic reset_cpu();
        rst_n       = 1'b0;
        force_ack   = 1'b0;
        wait_cycles = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cyc = 1;
    endtask

    logic [7:0] rv;
    int         bad;

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        wait_cnt    = 0;
        wait_cycles = 0;
        force_ack   = 1'b0;
        rst_n       = 1'b0;
        fill_mem();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_retire", 32'(retire), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // LI r1,5 ; LI r2,3 ; ADD r1,r2
        fill_mem();
        mem[0] = 8'hA4; mem[1] = 8'h05; mem[2] = 8'hA8; mem[3] = 8'h03; mem[4] = 8'h26;
        reset_cpu();
        rv = '0;
        rv[0] = retire;
        for (int k = 2; k <= 8; k++) begin
            step();
            rv[k-1] = retire;
        end
        chk("t1_retire_pattern", 32'(rv), 32'hA4);
        step();
        chk("t1_r1", 32'(dut.regs_q[1]), 32'h08);
        chk("t1_r2", 32'(dut.regs_q[2]), 32'h03);
        chk("t1_pc", 32'(pc), 32'h05);

        // COMP equal then JNZ not taken
        fill_mem();
        mem[0] = 8'hA4; mem[1] = 8'h07; mem[2] = 8'hA8; mem[3] = 8'h07;
        mem[4] = 8'h66; mem[5] = 8'hC0; mem[6] = 8'h10;
        reset_cpu();
        run_to(8);
        chk("t2_comp_op", 32'(alu_op), 32'h6);
        chk("t2_comp_ina", 32'(alu_ina), 32'h07);
        chk("t2_comp_inb", 32'(alu_inb), 32'h07);
        run_to(12);
        chk("t2_zf_eq", 32'(dut.zf_q), 32'h1);
        chk("t2_pc_nojump", 32'(pc), 32'h07);

        // COMP unequal then JNZ taken
        mem[3] = 8'h06;
        reset_cpu();
        run_to(12);
        chk("t2_zf_ne", 32'(dut.zf_q), 32'h0);
        chk("t2_pc_jump", 32'(pc), 32'h10);

        // STORE then LOAD with three wait states per transaction
        fill_mem();
        mem[0] = 8'hA4; mem[1] = 8'h2A; mem[2] = 8'hA8; mem[3] = 8'h40;
        mem[4] = 8'h96; mem[5] = 8'h8E; mem[8'h40] = 8'h00;
        reset_cpu();
        run_to(6);
        wait_cycles = 3;
        run_to(10);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_st_req", 32'(mem_req), 32'h1);
            chk("t3_st_we", 32'(mem_we), 32'h1);
            chk("t3_st_addr", 32'(mem_addr), 32'h40);
            chk("t3_st_wdata", 32'(mem_wdata), 32'h2A);
            chk("t3_st_retire", 32'(retire), (i == 3) ? 32'h1 : 32'h0);
        end
        run_to(22);
        chk("t3_ld_we", 32'(mem_we), 32'h0);
        chk("t3_ld_retire", 32'(retire), 32'h1);
        step();
        chk("t3_mem40", 32'(mem[8'h40]), 32'h2A);
        chk("t3_r3", 32'(dut.regs_q[3]), 32'h2A);
        chk("t3_pc", 32'(pc), 32'h06);

        // OR r0,r1 ; JMP 0xFF ; LI r1 whose immediate wraps to address 0
        fill_mem();
        mem[0] = 8'h11; mem[1] = 8'hB0; mem[2] = 8'hFF; mem[8'hFF] = 8'hA4;
        reset_cpu();
        run_to(6);
        chk("t4_fetch_ff", 32'(mem_addr), 32'hFF);
        step();
        chk("t4_imm_addr_wrap", 32'(mem_addr), 32'h00);
        chk("t4_pc_wrap", 32'(pc), 32'h00);
        run_to(9);
        chk("t4_r1", 32'(dut.regs_q[1]), 32'h11);
        chk("t4_pc", 32'(pc), 32'h01);

        // Reset during an IMM wait with ack arriving in the same cycle
        fill_mem();
        mem[0] = 8'hA4; mem[1] = 8'h55; mem[2] = 8'hA8; mem[3] = 8'h77;
        mem[4] = 8'hA4; mem[5] = 8'h99;
        reset_cpu();
        run_to(6);
        wait_cycles = 2;
        run_to(11);
        chk("t5_imm_req", 32'(mem_req), 32'h1);
        chk("t5_imm_addr", 32'(mem_addr), 32'h05);
        step();
        rst_n     = 1'b0;
        force_ack = 1'b1;
        #1;
        chk("t5_req_in_rst", 32'(mem_req), 32'h0);
        chk("t5_retire_in_rst", 32'(retire), 32'h0);
        step();
        chk("t5_pc_rst", 32'(pc), 32'h00);
        chk("t5_r1_rst", 32'(dut.regs_q[1]), 32'h00);
        chk("t5_r2_rst", 32'(dut.regs_q[2]), 32'h00);
        chk("t5_req_hold", 32'(mem_req), 32'h0);
        rst_n       = 1'b1;
        force_ack   = 1'b0;
        wait_cycles = 0;
        #1;
        chk("t5_refetch_req", 32'(mem_req), 32'h1);
        chk("t5_refetch_addr", 32'(mem_addr), 32'h00);

        // Opcode 15
        fill_mem();
        mem[0] = 8'hF0;
        reset_cpu();
        step();
`ifdef CPU_CTRL_HALT_EN
        chk("t6_halted", 32'(halted), 32'h1);
        chk("t6_no_retire", 32'(retire), 32'h0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req || retire || !halted) bad++;
        end
        chk("t6_halt_quiet", 32'(bad), 32'h0);
        chk("t6_pc", 32'(pc), 32'h01);
`else
        chk("t6_nop_retire", 32'(retire), 32'h1);
        chk("t6_not_halted", 32'(halted), 32'h0);
        chk("t6_pc", 32'(pc), 32'h01);
        step();
        chk("t6_next_req", 32'(mem_req), 32'h1);
        chk("t6_next_addr", 32'(mem_addr), 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
